// File: rtl/bp_pkg.sv
// Shared definitions for the 2-bit saturating branch predictor:
// counter encodings, state type and the next-state rule.
package bp_pkg;

   typedef logic [1:0] bp_state_t;

   localparam bp_state_t BP_STRONG_NT = 2'b00;
   localparam bp_state_t BP_WEAK_NT   = 2'b01;
   localparam bp_state_t BP_WEAK_T    = 2'b10;
   localparam bp_state_t BP_STRONG_T  = 2'b11;

   // Move one step toward the observed outcome, pinning at the strong ends.
   function automatic bp_state_t bp_sat_next(input bp_state_t state, input logic taken);
      bp_state_t nxt;
      nxt = state;
      if (taken) begin
         if (state != BP_STRONG_T) nxt = state + 2'd1;
      end else begin
         if (state != BP_STRONG_NT) nxt = state - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bp_sat_update.sv
// Combinational 2-bit saturating-counter update, kept separate so other
// predictor variants can share the same rule.
module bp_sat_update
   import bp_pkg::*;
(
   input  bp_state_t state_i,
   input  logic      taken_i,
   output bp_state_t state_o
);

   assign state_o = bp_sat_next(state_i, taken_i);

endmodule

// File: rtl/branch_resolve_update.sv
// Carries prediction state IF->ID->EX, resolves branches in EX, drives the
// predictor table write port and flush/redirect. Optional stats: BRANCH_STATS_EN.
module branch_resolve_update
   import bp_pkg::*;
#(
   parameter int PC_W  = 32,
   parameter int IDX_W = 2
`ifdef BRANCH_STATS_EN
   ,parameter int STAT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             valid_if,
   input  logic [PC_W-1:0]  pc_if,
   input  bp_state_t        pred_state_if,
   output logic             pred_taken_if,
   input  logic             is_branch_id,
   input  logic [PC_W-1:0]  target_id,
   input  logic             taken_ex,
   output logic             update_en,
   output logic [IDX_W-1:0] update_idx,
   output bp_state_t        update_entry,
   output logic             flush,
   output logic [PC_W-1:0]  redirect_pc
`ifdef BRANCH_STATS_EN
   ,output logic [STAT_W-1:0] pred_cnt,
   output logic [STAT_W-1:0] mispred_cnt
`endif
);

   logic            ifid_valid_q, ifid_valid_d;
   logic [PC_W-1:0] ifid_pc_q,    ifid_pc_d;
   bp_state_t       ifid_state_q, ifid_state_d;

   logic            idex_valid_q,  idex_valid_d;
   logic [PC_W-1:0] idex_pc_q,     idex_pc_d;
   bp_state_t       idex_state_q,  idex_state_d;
   logic            idex_br_q,     idex_br_d;
   logic [PC_W-1:0] idex_target_q, idex_target_d;

   logic      ex_br;
   logic      ex_mispred;
   bp_state_t ex_next_state;

   assign pred_taken_if = pred_state_if[1];

   always_comb begin
      ifid_valid_d  = ifid_valid_q;
      ifid_pc_d     = ifid_pc_q;
      ifid_state_d  = ifid_state_q;
      idex_valid_d  = idex_valid_q;
      idex_pc_d     = idex_pc_q;
      idex_state_d  = idex_state_q;
      idex_br_d     = idex_br_q;
      idex_target_d = idex_target_q;
      // flush can only be high when stall is low, so it always advances the pipe
      if (flush || !stall) begin
         ifid_valid_d  = valid_if & ~flush;
         ifid_pc_d     = pc_if;
         ifid_state_d  = pred_state_if;
         idex_valid_d  = ifid_valid_q & ~flush;
         idex_pc_d     = ifid_pc_q;
         idex_state_d  = ifid_state_q;
         idex_br_d     = is_branch_id;
         idex_target_d = target_id;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ifid_valid_q  <= 1'b0;
         ifid_pc_q     <= '0;
         ifid_state_q  <= BP_STRONG_NT;
         idex_valid_q  <= 1'b0;
         idex_pc_q     <= '0;
         idex_state_q  <= BP_STRONG_NT;
         idex_br_q     <= 1'b0;
         idex_target_q <= '0;
      end else begin
         ifid_valid_q  <= ifid_valid_d;
         ifid_pc_q     <= ifid_pc_d;
         ifid_state_q  <= ifid_state_d;
         idex_valid_q  <= idex_valid_d;
         idex_pc_q     <= idex_pc_d;
         idex_state_q  <= idex_state_d;
         idex_br_q     <= idex_br_d;
         idex_target_q <= idex_target_d;
      end
   end

   bp_sat_update u_sat (
      .state_i (idex_state_q),
      .taken_i (taken_ex),
      .state_o (ex_next_state)
   );

   // Reset in flight suppresses the write so a discarded branch never reaches the table.
   assign ex_br      = idex_valid_q & idex_br_q & ~stall & ~reset;
   assign ex_mispred = idex_state_q[1] ^ taken_ex;

   // Write-port payload is held at zero whenever no write is requested.
   assign update_en    = ex_br;
   assign update_idx   = ex_br ? idex_pc_q[IDX_W+1:2] : '0;
   assign update_entry = ex_br ? ex_next_state : BP_STRONG_NT;
   assign flush        = ex_br & ex_mispred;
   assign redirect_pc  = !flush   ? '0 :
                         taken_ex ? idex_target_q : idex_pc_q + PC_W'(4);

`ifdef BRANCH_STATS_EN
   logic [STAT_W-1:0] pred_cnt_q;
   logic [STAT_W-1:0] mispred_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         pred_cnt_q    <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (update_en && (pred_cnt_q != '1))   pred_cnt_q    <= pred_cnt_q + STAT_W'(1);
         if (flush && (mispred_cnt_q != '1))    mispred_cnt_q <= mispred_cnt_q + STAT_W'(1);
      end
   end

   assign pred_cnt    = pred_cnt_q;
   assign mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_update.sv
// Bench for branch_resolve_update: directed scenarios then random traffic,
// checked against an instruction-level pipeline and table model.
module tb_branch_resolve_update;

   typedef struct packed {
      logic        v;
      logic [31:0] pc;
      logic [1:0]  st;
      logic        br;
      logic [31:0] tgt;
      logic        tk;
   } ins_t;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        valid_if;
   logic [31:0] pc_if;
   logic [1:0]  pred_state_if;
   logic        pred_taken_if;
   logic        is_branch_id;
   logic [31:0] target_id;
   logic        taken_ex;
   logic        update_en;
   logic [1:0]  update_idx;
   logic [1:0]  update_entry;
   logic        flush;
   logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
   logic [3:0]  pred_cnt;
   logic [3:0]  mispred_cnt;
`endif

   branch_resolve_update #(
      .PC_W  (32),
      .IDX_W (2)
`ifdef BRANCH_STATS_EN
      ,.STAT_W (4)
`endif
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .valid_if      (valid_if),
      .pc_if         (pc_if),
      .pred_state_if (pred_state_if),
      .pred_taken_if (pred_taken_if),
      .is_branch_id  (is_branch_id),
      .target_id     (target_id),
      .taken_ex      (taken_ex),
      .update_en     (update_en),
      .update_idx    (update_idx),
      .update_entry  (update_entry),
      .flush         (flush),
      .redirect_pc   (redirect_pc)
`ifdef BRANCH_STATS_EN
      ,.pred_cnt     (pred_cnt),
      .mispred_cnt   (mispred_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ins_t       ifn, idm, exm;
   logic [1:0] tbl [4];
   int         n_assert = 0;
   int         n_fail   = 0;
   int         exp_pred = 0;
   int         exp_mis  = 0;
   bit         stats_ok = 0;
   int         seen_flush = 0;
   int         seen_upd   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive from the model, check EX outputs, then advance the model.
   task automatic step();
      bit          ebr, efl;
      int          s;
      logic [31:0] ered;
      logic [1:0]  eent;
      valid_if      = ifn.v;
      pc_if         = ifn.pc;
      pred_state_if = tbl[ifn.pc[3:2]];
      ifn.st        = pred_state_if;
      is_branch_id  = idm.br;
      target_id     = idm.tgt;
      taken_ex      = exm.tk;
      #1;
      ebr = exm.v && exm.br && !stall && !reset;
      s = int'(exm.st) + (exm.tk ? 1 : -1);
      if (s > 3) s = 3;
      if (s < 0) s = 0;
      eent = 2'(s);
      efl  = ebr && ((exm.st >= 2) != exm.tk);
      ered = !efl ? 32'd0 : (exm.tk ? exm.tgt : exm.pc + 32'd4);
      chk("pred_taken_if", {31'd0, pred_taken_if}, {31'd0, ifn.st >= 2});
      chk("update_en",     {31'd0, update_en},     {31'd0, ebr});
      chk("flush",         {31'd0, flush},         {31'd0, efl});
      chk("redirect_pc",   redirect_pc,            ered);
      chk("update_idx",    {30'd0, update_idx},    ebr ? {30'd0, exm.pc[3:2]} : 32'd0);
      chk("update_entry",  {30'd0, update_entry},  ebr ? {30'd0, eent} : 32'd0);
`ifdef BRANCH_STATS_EN
      if (stats_ok) begin
         chk("pred_cnt",    {28'd0, pred_cnt},    exp_pred);
         chk("mispred_cnt", {28'd0, mispred_cnt}, exp_mis);
      end
`endif
      seen_flush += int'(flush);
      seen_upd   += int'(update_en);
      @(posedge clk);
      if (ebr) tbl[exm.pc[3:2]] = eent;
      if (reset) begin
         idm = '0; exm = '0; exp_pred = 0; exp_mis = 0; stats_ok = 1;
      end else begin
         if (ebr && exp_pred < 15) exp_pred++;
         if (efl && exp_mis < 15)  exp_mis++;
         if (efl) begin
            exm = idm; exm.v = 1'b0;
            idm = ifn; idm.v = 1'b0;
         end else if (!stall) begin
            exm = idm;
            idm = ifn;
         end
      end
      @(negedge clk);
   endtask

   task automatic issue(input bit v, input logic [31:0] pc, input bit br,
                        input logic [31:0] tgt, input bit tk, input bit stl);
      ifn = '0;
      ifn.v = v; ifn.pc = pc; ifn.br = br; ifn.tgt = tgt; ifn.tk = tk;
      stall = stl;
      reset = 1'b0;
      step();
   endtask

   task automatic bubble(input int n, input bit stl);
      for (int i = 0; i < n; i++) issue(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, stl);
   endtask

   task automatic do_reset(input int n);
      ifn = '0; stall = 1'b0;
      for (int i = 0; i < n; i++) begin
         reset = 1'b1;
         step();
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; valid_if = 1'b0; pc_if = '0; pred_state_if = '0;
      is_branch_id = 1'b0; target_id = '0; taken_ex = 1'b0;
      ifn = '0; idm = '0; exm = '0;
      for (int i = 0; i < 4; i++) tbl[i] = 2'b00;
      @(negedge clk);
      do_reset(2);

      // T1: saturate up at index 1
      tbl[1] = 2'b10;
      for (int i = 0; i < 3; i++) issue(1'b1, 32'h4, 1'b1, 32'h400, 1'b1, 1'b0);
      bubble(3, 1'b0);

      // T2: strong-NT predicted, taken -> redirect to target; followers killed
      tbl[0] = 2'b00; tbl[1] = 2'b00; tbl[2] = 2'b00;
      issue(1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 1'b0);
      issue(1'b1, 32'h44, 1'b1, 32'h90, 1'b1, 1'b0);
      issue(1'b1, 32'h48, 1'b1, 32'hA0, 1'b1, 1'b0);
      bubble(3, 1'b0);

      // T3: strong-T predicted, not taken -> fall through, including PC wrap
      tbl[0] = 2'b11;
      issue(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0);
      bubble(2, 1'b0);
      tbl[3] = 2'b11;
      issue(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h300, 1'b0, 1'b0);
      bubble(2, 1'b0);

      // T4: mispredict held by stall for 3 cycles, resolves once stall drops
      tbl[2] = 2'b01;
      issue(1'b1, 32'h208, 1'b1, 32'h500, 1'b1, 1'b0);
      bubble(1, 1'b0);
      seen_flush = 0; seen_upd = 0;
      bubble(3, 1'b1);
      chk("t4_flush_during_stall",  seen_flush, 0);
      chk("t4_update_during_stall", seen_upd, 0);
      bubble(3, 1'b0);
      chk("t4_flush_total",  seen_flush, 1);
      chk("t4_update_total", seen_upd, 1);

      // T5: reset while a mispredicting branch sits in ID
      tbl[1] = 2'b00;
      issue(1'b1, 32'h14, 1'b1, 32'h600, 1'b1, 1'b0);
      seen_flush = 0; seen_upd = 0;
      do_reset(1);
      bubble(3, 1'b0);
      chk("t5_no_update", seen_upd, 0);
      chk("t5_no_flush",  seen_flush, 0);

`ifdef BRANCH_STATS_EN
      // T6: mispredict counter saturates
      do_reset(1);
      for (int i = 0; i < 20; i++) begin
         tbl[i % 4] = 2'b00;
         issue(1'b1, 32'(32'h300 + 4 * (i % 4)), 1'b1, 32'h700, 1'b1, 1'b0);
         bubble(2, 1'b0);
      end
      bubble(1, 1'b0);
      chk("t6_mispred_sat", {28'd0, mispred_cnt}, 32'd15);
      chk("t6_pred_sat",    {28'd0, pred_cnt},    32'd15);
`endif

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         ifn = '0;
         ifn.v   = ($urandom_range(3) != 0);
         ifn.pc  = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : {24'd0, 6'($urandom_range(63)), 2'b00};
         ifn.br  = $urandom_range(1) == 1;
         ifn.tgt = $urandom & 32'hFFFF_FFFC;
         ifn.tk  = $urandom_range(1) == 1;
         stall   = ($urandom_range(4) == 0);
         reset   = ($urandom_range(63) == 0);
         step();
      end
      reset = 1'b0;
      bubble(2, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
